spike_rate_decoder: RTL and testbench

Downstream consumer of the spiking_neuron spike output. It converts the 1-bit spike train into a spike count over a programmable window of back-to-back cycles, and measures the inter-spike interval (ISI). Each window result is presented through a single-entry valid/ready output buffer, so the top level or the next layer can sample firing rate without losing data silently.

---
 rtl/spike_rate_decoder.sv | 212 +++++++++++++++++++++
 tb/tb_spike_rate_decoder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: turns a 1-bit spike train into per-window spike counts
// held in a single-entry valid/ready buffer, and tracks the inter-spike interval.
// Each enabled posedge is one window cycle; the edge that leaves IDLE is cycle 1.
// cyc_r holds the number of cycles already counted in the current window, so the
// edge being processed is cycle cyc_r+1 and the window closes on the edge whose
// cycle index equals the latched length (a window started at edge E closes at E+N-1).
module spike_rate_decoder #(
  parameter int WINDOW_W    = 8,
  parameter int CNT_W       = 8,
  parameter int EDGE_DETECT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                spike,
  input  logic [WINDOW_W-1:0] window_len,
  output logic [CNT_W-1:0]    rate,
  output logic                rate_sat,
  output logic                rate_valid,
  input  logic                rate_ready,
  output logic                overrun,
  output logic [CNT_W-1:0]    last_isi,
  output logic                isi_valid
);

  localparam logic [CNT_W-1:0]    CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]    CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [WINDOW_W-1:0] W_ZERO   = {WINDOW_W{1'b0}};
  localparam logic [WINDOW_W-1:0] W_ONE    = {{(WINDOW_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

  // Saturating increment: never wraps past the all-ones value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != CNT_MAX)) begin
      sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      sat_inc = v;
    end
  endfunction

  state_t              state_r;
  logic                spike_q_r;
  logic [WINDOW_W-1:0] len_r;
  logic [WINDOW_W-1:0] cyc_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                win_sat_r;
  logic [CNT_W-1:0]    rate_r;
  logic                rate_sat_r;
  logic                rate_valid_r;
  logic                overrun_r;
  logic [CNT_W-1:0]    isi_cnt_r;
  logic                seen_r;
  logic [CNT_W-1:0]    last_isi_r;
  logic                isi_valid_r;

  logic                event_s;
  logic [WINDOW_W-1:0] len_eff_s;
  logic [WINDOW_W-1:0] cur_cyc_s;
  logic [WINDOW_W-1:0] cur_len_s;
  logic [CNT_W-1:0]    cur_cnt_s;
  logic                cur_sat_s;
  logic                win_end_s;
  logic [CNT_W-1:0]    final_cnt_s;
  logic                final_sat_s;
  logic                load_s;

  // Event detection, window-cycle bookkeeping and buffer-load decision.
  always_comb begin
    event_s     = 1'b0;
    len_eff_s   = window_len;
    cur_cyc_s   = W_ONE;
    cur_len_s   = W_ONE;
    cur_cnt_s   = CNT_ZERO;
    cur_sat_s   = 1'b0;
    if (EDGE_DETECT != 0) begin
      event_s = spike & ~spike_q_r;
    end else begin
      event_s = spike;
    end
    if (window_len == W_ZERO) begin
      len_eff_s = W_ONE;
    end else begin
      len_eff_s = window_len;
    end
    case (state_r)
      ST_COUNT: begin
        cur_cyc_s = cyc_r + W_ONE;
        cur_len_s = len_r;
        cur_cnt_s = cnt_r;
        cur_sat_s = win_sat_r;
      end
      default: begin
        // Leaving IDLE: this edge is cycle 1 of a fresh window.
        cur_cyc_s = W_ONE;
        cur_len_s = len_eff_s;
        cur_cnt_s = CNT_ZERO;
        cur_sat_s = 1'b0;
      end
    endcase
    win_end_s   = ena & (cur_cyc_s == cur_len_s);
    final_cnt_s = sat_inc(cur_cnt_s, event_s);
    final_sat_s = cur_sat_s | (event_s & (cur_cnt_s == CNT_MAX));
    load_s      = win_end_s & (~rate_valid_r | rate_ready);
  end

  // Spike delay register for edge detection; runs in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_q_r <= 1'b0;
    end else begin
      spike_q_r <= spike;
    end
  end

  // Window FSM: counts events over back-to-back windows, clears when disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      len_r     <= W_ZERO;
      cyc_r     <= W_ZERO;
      cnt_r     <= CNT_ZERO;
      win_sat_r <= 1'b0;
    end else if (!ena) begin
      state_r   <= ST_IDLE;
      cyc_r     <= W_ZERO;
      cnt_r     <= CNT_ZERO;
      win_sat_r <= 1'b0;
    end else if (win_end_s) begin
      // Next window starts on the following edge; its length is sampled now.
      state_r   <= ST_COUNT;
      len_r     <= len_eff_s;
      cyc_r     <= W_ZERO;
      cnt_r     <= CNT_ZERO;
      win_sat_r <= 1'b0;
    end else begin
      state_r   <= ST_COUNT;
      len_r     <= cur_len_s;
      cyc_r     <= cur_cyc_s;
      cnt_r     <= final_cnt_s;
      win_sat_r <= final_sat_s;
    end
  end

  // Single-entry result buffer with simultaneous consume-and-load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rate_r       <= CNT_ZERO;
      rate_sat_r   <= 1'b0;
      rate_valid_r <= 1'b0;
    end else if (load_s) begin
      rate_r       <= final_cnt_s;
      rate_sat_r   <= final_sat_s;
      rate_valid_r <= 1'b1;
    end else if (rate_valid_r && rate_ready) begin
      rate_valid_r <= 1'b0;
    end else begin
      rate_valid_r <= rate_valid_r;
    end
  end

  // Sticky drop flag: set when a result finds the buffer full, cleared by ena low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_r <= 1'b0;
    end else if (!ena) begin
      overrun_r <= 1'b0;
    end else if (win_end_s && !load_s) begin
      overrun_r <= 1'b1;
    end else begin
      overrun_r <= overrun_r;
    end
  end

  // Inter-spike interval tracker, measured in enabled edges between events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isi_cnt_r   <= CNT_ZERO;
      seen_r      <= 1'b0;
      last_isi_r  <= CNT_ZERO;
      isi_valid_r <= 1'b0;
    end else if (!ena) begin
      isi_cnt_r   <= CNT_ZERO;
      seen_r      <= 1'b0;
      last_isi_r  <= CNT_ZERO;
      isi_valid_r <= 1'b0;
    end else if (event_s) begin
      if (seen_r) begin
        last_isi_r  <= sat_inc(isi_cnt_r, 1'b1);
        isi_valid_r <= 1'b1;
      end else begin
        last_isi_r  <= last_isi_r;
        isi_valid_r <= isi_valid_r;
      end
      isi_cnt_r <= CNT_ZERO;
      seen_r    <= 1'b1;
    end else begin
      isi_cnt_r <= sat_inc(isi_cnt_r, 1'b1);
    end
  end

  assign rate       = rate_r;
  assign rate_sat   = rate_sat_r;
  assign rate_valid = rate_valid_r;
  assign overrun    = overrun_r;
  assign last_isi   = last_isi_r;
  assign isi_valid  = isi_valid_r;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: a default instance (edge counting,
// 8-bit counts) and a level-counting instance with 4-bit counts.
module tb_spike_rate_decoder;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       ena, spike, rate_ready;
  logic [7:0] window_len;
  logic [7:0] rate, last_isi;
  logic       rate_sat, rate_valid, overrun, isi_valid;

  logic       ena0, spike0, rate_ready0;
  logic [7:0] window_len0;
  logic [3:0] rate0, last_isi0;
  logic       rate_sat0, rate_valid0, overrun0, isi_valid0;

  int n_cmp = 0;
  int n_err = 0;

  spike_rate_decoder #(.WINDOW_W(8), .CNT_W(8), .EDGE_DETECT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .spike(spike), .window_len(window_len),
    .rate(rate), .rate_sat(rate_sat), .rate_valid(rate_valid), .rate_ready(rate_ready),
    .overrun(overrun), .last_isi(last_isi), .isi_valid(isi_valid)
  );

  spike_rate_decoder #(.WINDOW_W(8), .CNT_W(4), .EDGE_DETECT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .ena(ena0), .spike(spike0), .window_len(window_len0),
    .rate(rate0), .rate_sat(rate_sat0), .rate_valid(rate_valid0), .rate_ready(rate_ready0),
    .overrun(overrun0), .last_isi(last_isi0), .isi_valid(isi_valid0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    ena = 1'b0; spike = 1'b0; rate_ready = 1'b0; window_len = 8'd10;
    ena0 = 1'b0; spike0 = 1'b0; rate_ready0 = 1'b0; window_len0 = 8'd20;
    #1 rst_n = 1'b0;
    #1;
    check("reset_rate", 32'(rate), 32'd0);
    check("reset_valid", 32'(rate_valid), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    check("reset_isi_valid", 32'(isi_valid), 32'd0);
    check("reset_rate0", 32'(rate0), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Pulses on window cycles 1,4,7,10 of a 10-cycle window.
    ena = 1'b1; window_len = 8'd10; rate_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      spike = (k == 1 || k == 4 || k == 7 || k == 10);
      tick();
      if (k < 10) check("t1_valid_early", 32'(rate_valid), 32'd0);
    end
    check("t1_rate", 32'(rate), 32'd4);
    check("t1_sat", 32'(rate_sat), 32'd0);
    check("t1_valid", 32'(rate_valid), 32'd1);
    check("t1_last_isi", 32'(last_isi), 32'd3);
    check("t1_isi_valid", 32'(isi_valid), 32'd1);
    spike = 1'b0;
    tick();
    check("t1_valid_pulse", 32'(rate_valid), 32'd0);
    ena = 1'b0;
    tick();
    check("t1_isi_clear", 32'(isi_valid), 32'd0);
    check("t1_rate_kept", 32'(rate), 32'd4);

    // Spike held high for two windows: only the rising edge counts.
    ena = 1'b1; spike = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 10) begin
        check("t2_w1_rate", 32'(rate), 32'd1);
        check("t2_w1_valid", 32'(rate_valid), 32'd1);
      end
      if (k == 11) check("t2_consumed", 32'(rate_valid), 32'd0);
    end
    check("t2_w2_rate", 32'(rate), 32'd0);
    check("t2_w2_valid", 32'(rate_valid), 32'd1);
    check("t2_isi_valid", 32'(isi_valid), 32'd0);
    spike = 1'b0; ena = 1'b0;
    tick();

    // Backpressure: consumer stalls, second window is dropped.
    ena = 1'b1; window_len = 8'd5;
    for (int k = 1; k <= 15; k++) begin
      spike = ((k % 5) == 1) || ((k % 5) == 3);
      rate_ready = (k >= 13);
      tick();
      if (k == 5) begin
        check("t4_rate_first", 32'(rate), 32'd2);
        check("t4_valid_first", 32'(rate_valid), 32'd1);
        check("t4_no_overrun", 32'(overrun), 32'd0);
      end
      if (k == 10) begin
        check("t4_overrun", 32'(overrun), 32'd1);
        check("t4_rate_held", 32'(rate), 32'd2);
      end
      if (k == 12) check("t4_valid_held", 32'(rate_valid), 32'd1);
      if (k == 13) begin
        check("t4_valid_fall", 32'(rate_valid), 32'd0);
        check("t4_overrun_sticky", 32'(overrun), 32'd1);
      end
      if (k == 15) begin
        check("t4_reload", 32'(rate_valid), 32'd1);
        check("t4_overrun_still", 32'(overrun), 32'd1);
      end
    end
    spike = 1'b0; ena = 1'b0;
    tick();
    check("t4_overrun_clear", 32'(overrun), 32'd0);

    // Asynchronous reset in the middle of a window with a held result.
    ena = 1'b1; window_len = 8'd5; rate_ready = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      spike = (k == 1 || k == 3);
      tick();
    end
    check("t5_pre_valid", 32'(rate_valid), 32'd1);
    check("t5_pre_isi", 32'(last_isi), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rate", 32'(rate), 32'd0);
    check("t5_valid", 32'(rate_valid), 32'd0);
    check("t5_overrun", 32'(overrun), 32'd0);
    check("t5_last_isi", 32'(last_isi), 32'd0);
    check("t5_isi_valid", 32'(isi_valid), 32'd0);
    tick();
    rst_n = 1'b1; rate_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      spike = (k == 2 || k == 5);
      tick();
      if (k == 4) check("t5_restart_early", 32'(rate_valid), 32'd0);
    end
    check("t5_restart_rate", 32'(rate), 32'd2);
    check("t5_restart_valid", 32'(rate_valid), 32'd1);
    spike = 1'b0; ena = 1'b0;
    tick();

    // Level counting with 4-bit saturation over a 20-cycle window.
    ena0 = 1'b1; window_len0 = 8'd20; spike0 = 1'b1; rate_ready0 = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 19) check("t3_valid_early", 32'(rate_valid0), 32'd0);
    end
    check("t3_rate", 32'(rate0), 32'd15);
    check("t3_sat", 32'(rate_sat0), 32'd1);
    check("t3_valid", 32'(rate_valid0), 32'd1);
    check("t3_last_isi", 32'(last_isi0), 32'd1);
    ena0 = 1'b0; spike0 = 1'b0;
    tick();

    // window_len 0 behaves as 1: a result every cycle.
    ena0 = 1'b1; window_len0 = 8'd0;
    for (int k = 1; k <= 8; k++) begin
      spike0 = (k % 2) == 1;
      tick();
      check("t6_valid", 32'(rate_valid0), 32'd1);
      check("t6_rate", 32'(rate0), ((k % 2) == 1) ? 32'd1 : 32'd0);
      check("t6_overrun", 32'(overrun0), 32'd0);
    end
    check("t6_sat", 32'(rate_sat0), 32'd0);
    ena0 = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
